shift_frame_ctrl: RTL and testbench

Serial-to-parallel frame controller that sequences an enable-gated shift register.
- Detects frame start, shifts exactly WIDTH data bits MSB-first, then optionally checks one parity bit.
- Presents the assembled word on a valid/ready output handshake.
- Sits between a serial link front-end and the parallel consumer logic.

---
 rtl/shift_frame_pkg.sv | 16 +
 rtl/shift_frame_ctrl_if.sv | 29 ++
 rtl/frame_shift_reg.sv | 28 ++
 rtl/shift_frame_ctrl.sv | 160 ++++++++++++++++
 tb/tb_shift_frame_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_frame_pkg.sv
// Shared types and helpers for the serial-to-parallel frame controller.
package shift_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Bit-counter width; the count leaves SHIFT at WIDTH-1, so it never needs WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_frame_ctrl_if.sv
// Serial input and parallel valid/ready output bundle of the frame controller.
interface shift_frame_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             frame_start;
  logic             ser_valid;
  logic             ser_data;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             parity_err;
  logic             overrun;
  logic             frame_abort;
  logic             busy;

  // Front-end/consumer side.
  modport master (
    output frame_start, ser_valid, ser_data, out_ready,
    input  out_valid, out_data, parity_err, overrun, frame_abort, busy
  );

  // Controller side.
  modport slave (
    input  frame_start, ser_valid, ser_data, out_ready,
    output out_valid, out_data, parity_err, overrun, frame_abort, busy
  );

endinterface

// File: rtl/frame_shift_reg.sv
// WIDTH-bit left-shift register, serial in at bit 0, synchronous clear.
module frame_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_shift_en,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (i_clear) begin
      r_data <= '0;
    end else if (i_shift_en) begin
      r_data <= {r_data[WIDTH-2:0], i_serial_in};
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/shift_frame_ctrl.sv
// Frame controller: start detect, MSB-first shift of WIDTH bits, optional
// parity check, and a valid/ready hold stage with overrun/abort reporting.
module shift_frame_ctrl
  import shift_frame_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  shift_frame_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_par_run;
  logic             r_parity_err;
  logic             r_overrun;
  logic             r_frame_abort;

  logic             w_start;
  logic             w_shift;
  logic             w_par_load;
  logic             w_overrun;
  logic             w_abort;
  logic             w_busy;
  logic             w_valid;
  logic             w_last_bit;
  logic             w_xfer;
  logic [WIDTH-1:0] w_shift_data;

  assign w_last_bit = (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_xfer     = (r_state == HOLD) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.frame_start) w_next = SHIFT;
      end
      SHIFT: begin
        if (bus.frame_start) begin
          w_next = SHIFT;
        end else if (bus.ser_valid && w_last_bit) begin
          if (PARITY_EN) w_next = PARITY;
          else           w_next = HOLD;
        end
      end
      PARITY: begin
        if (bus.frame_start)    w_next = SHIFT;
        else if (bus.ser_valid) w_next = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) w_next = bus.frame_start ? SHIFT : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // A frame_start accepted in a transfer cycle restarts cleanly and is not an overrun.
  always_comb begin
    w_start    = 1'b0;
    w_shift    = 1'b0;
    w_par_load = 1'b0;
    w_overrun  = 1'b0;
    w_abort    = 1'b0;
    w_busy     = 1'b0;
    w_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = bus.frame_start;
      end
      SHIFT: begin
        w_busy = 1'b1;
        if (bus.frame_start) begin
          w_start = 1'b1;
          w_abort = 1'b1;
        end else begin
          w_shift = bus.ser_valid;
        end
      end
      PARITY: begin
        w_busy = 1'b1;
        if (bus.frame_start) begin
          w_start = 1'b1;
          w_abort = 1'b1;
        end else begin
          w_par_load = bus.ser_valid;
        end
      end
      HOLD: begin
        w_valid = 1'b1;
        if (bus.out_ready) begin
          w_start   = bus.frame_start;
          w_overrun = bus.ser_valid && !bus.frame_start;
        end else begin
          w_overrun = bus.ser_valid || bus.frame_start;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bit_cnt     <= '0;
      r_par_run     <= 1'b0;
      r_parity_err  <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_overrun     <= w_overrun;
      r_frame_abort <= w_abort;
      if (w_start) begin
        r_bit_cnt <= '0;
        r_par_run <= 1'b0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        r_par_run <= r_par_run ^ bus.ser_data;
      end
      if (w_par_load) begin
        r_parity_err <= r_par_run ^ bus.ser_data ^ ODD_PARITY;
      end else if (w_xfer) begin
        r_parity_err <= 1'b0;
      end
    end
  end

  frame_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (w_start),
    .i_shift_en  (w_shift),
    .i_serial_in (bus.ser_data),
    .o_data      (w_shift_data)
  );

  assign bus.out_valid   = w_valid;
  assign bus.busy        = w_busy;
  assign bus.out_data    = w_shift_data;
  assign bus.parity_err  = r_parity_err;
  assign bus.overrun     = r_overrun;
  assign bus.frame_abort = r_frame_abort;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Three controllers (even parity, odd parity, no parity) share one stimulus
// stream; each is checked against a frame-level model plus directed sequences.
module tb_shift_frame_ctrl;

  localparam int W = 8;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic fs = 1'b0, sv = 1'b0, sd = 1'b0, rdy = 1'b0;

  logic         act_valid [N];
  logic         act_busy  [N];
  logic         act_ov    [N];
  logic         act_ab    [N];
  logic         act_perr  [N];
  logic [W-1:0] act_data  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam bit PE = (g != 2);
    localparam bit OD = (g == 1);
    shift_frame_ctrl_if #(.WIDTH(W)) u_if ();
    assign u_if.frame_start = fs;
    assign u_if.ser_valid   = sv;
    assign u_if.ser_data    = sd;
    assign u_if.out_ready   = rdy;
    assign act_valid[g] = u_if.out_valid;
    assign act_busy[g]  = u_if.busy;
    assign act_ov[g]    = u_if.overrun;
    assign act_ab[g]    = u_if.frame_abort;
    assign act_perr[g]  = u_if.parity_err;
    assign act_data[g]  = u_if.out_data;
    shift_frame_ctrl #(.WIDTH(W), .PARITY_EN(PE), .ODD_PARITY(OD)) u_dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (u_if.slave)
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int ov_count = 0;
  int ab_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: collects data bits arithmetically, then holds the word.
  bit m_active [N];
  bit m_hold   [N];
  bit m_ov     [N];
  bit m_ab     [N];
  bit m_perr   [N];
  int m_cnt    [N];
  int m_word   [N];
  int m_ones   [N];

  task automatic m_start(input int m);
    m_active[m] = 1; m_cnt[m] = 0; m_word[m] = 0; m_ones[m] = 0;
  endtask

  task automatic m_finish(input int m);
    m_active[m] = 0; m_hold[m] = 1;
  endtask

  task automatic model_step(input int m);
    bit pe, odd;
    pe  = (m != 2);
    odd = (m == 1);
    m_ov[m] = 0;
    m_ab[m] = 0;
    if (!rst_n) begin
      m_active[m] = 0; m_hold[m] = 0; m_perr[m] = 0;
      m_cnt[m] = 0; m_word[m] = 0; m_ones[m] = 0;
    end else if (m_hold[m]) begin
      if (rdy) begin
        m_hold[m] = 0;
        m_perr[m] = 0;
        if (fs) m_start(m);
        else if (sv) m_ov[m] = 1;
      end else if (sv || fs) begin
        m_ov[m] = 1;
      end
    end else if (m_active[m]) begin
      if (fs) begin
        m_ab[m] = 1;
        m_start(m);
      end else if (sv) begin
        if (m_cnt[m] < W) begin
          m_word[m] = m_word[m] * 2 + int'(sd);
          m_ones[m] += int'(sd);
          m_cnt[m]++;
          if (m_cnt[m] == W && !pe) m_finish(m);
        end else begin
          m_perr[m] = (((m_ones[m] + int'(sd)) % 2) != int'(odd));
          m_finish(m);
        end
      end
    end else if (fs) begin
      m_start(m);
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < N; m++) begin
      check($sformatf("model_valid%0d", m), act_valid[m], m_hold[m]);
      check($sformatf("model_busy%0d", m), act_busy[m], m_active[m]);
      check($sformatf("model_overrun%0d", m), act_ov[m], m_ov[m]);
      check($sformatf("model_abort%0d", m), act_ab[m], m_ab[m]);
      check($sformatf("model_perr%0d", m), act_perr[m], m_perr[m]);
      if (m_hold[m]) check($sformatf("model_data%0d", m), act_data[m], m_word[m]);
    end
  endtask

  task automatic step(input logic f, input logic v, input logic d, input logic r,
                      input logic rs = 1'b1);
    @(negedge clk);
    fs = f; sv = v; sd = d; rdy = r; rst_n = rs;
    @(posedge clk);
    for (int m = 0; m < N; m++) model_step(m);
    #1;
    compare_all();
    ov_count += int'(act_ov[0]);
    ab_count += int'(act_ab[0]);
  endtask

  task automatic send_word(input int value, input int nbits);
    for (int i = W - 1; i >= W - nbits; i--) step(1'b0, 1'b1, 1'((value >> i) & 1), 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       fs, sv, sd, rdy;
    logic       e_valid, e_busy, e_ov, e_ab, e_perr;
    logic [7:0] e_data;
  } vec_t;

  vec_t       tbl [11];
  logic [7:0] pat;

  initial begin
    pat    = 8'hB2;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < 8; i++)
      tbl[1+i] = '{1'b0, 1'b1, pat[7-i], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hB2};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    // Reset state.
    do_reset();
    for (int m = 0; m < N; m++) begin
      check($sformatf("rst_valid%0d", m), act_valid[m], 0);
      check($sformatf("rst_busy%0d", m), act_busy[m], 0);
      check($sformatf("rst_data%0d", m), act_data[m], 0);
      check($sformatf("rst_perr%0d", m), act_perr[m], 0);
    end

    // Even-parity frame 0xB2, parity 0, then transfer.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].fs, tbl[i].sv, tbl[i].sd, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), act_valid[0], tbl[i].e_valid);
      check($sformatf("tbl%0d_busy", i), act_busy[0], tbl[i].e_busy);
      check($sformatf("tbl%0d_overrun", i), act_ov[0], tbl[i].e_ov);
      check($sformatf("tbl%0d_abort", i), act_ab[0], tbl[i].e_ab);
      check($sformatf("tbl%0d_perr", i), act_perr[0], tbl[i].e_perr);
      if (tbl[i].e_valid) check($sformatf("tbl%0d_data", i), act_data[0], tbl[i].e_data);
    end

    // Parity bit 1: even checker flags it, odd checker accepts it.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(32'hB2, 8);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("par1_even_perr", act_perr[0], 1);
    check("par1_odd_perr", act_perr[1], 0);
    check("par1_even_data", act_data[0], 8'hB2);
    check("par1_odd_data", act_data[1], 8'hB2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("par1_perr_cleared", act_perr[0], 0);

    // No-parity instance: 0xA5 with 3-cycle stalls between bits.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, 1'((32'hA5 >> i) & 1), 1'b0);
      if (i > 0) begin
        check($sformatf("gap_busy_bit%0d", i), act_busy[2], 1);
        for (int k = 0; k < 3; k++) begin
          step(1'b0, 1'b0, 1'b0, 1'b0);
          check($sformatf("gap_busy_stall%0d_%0d", i, k), act_busy[2], 1);
        end
      end
    end
    check("gap_valid", act_valid[2], 1);
    check("gap_data", act_data[2], 8'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("gap_xfer_valid", act_valid[2], 0);

    // Overrun while holding with out_ready low.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(32'hB2, 8);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ov_count = 0;
    for (int k = 0; k < 5; k++) step(1'b0, 1'((k == 1) || (k == 3)), 1'($urandom_range(0, 1)), 1'b0);
    check("ovr_pulses", ov_count, 2);
    check("ovr_data_kept", act_data[0], 8'hB2);
    check("ovr_still_valid", act_valid[0], 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_xfer_valid", act_valid[0], 0);

    // Abort after 4 bits, then a fresh frame 0x3C.
    do_reset();
    ab_count = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(32'hF0, 4);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("abort_pulse", act_ab[0], 1);
    send_word(32'h3C, 8);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("abort_valid", act_valid[0], 1);
    check("abort_data", act_data[0], 8'h3C);
    check("abort_count", ab_count, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame after 5 bits, then frame 0x81.
    do_reset();
    ab_count = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(32'hFF, 5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int m = 0; m < N; m++) begin
      check($sformatf("mid_rst_valid%0d", m), act_valid[m], 0);
      check($sformatf("mid_rst_busy%0d", m), act_busy[m], 0);
      check($sformatf("mid_rst_data%0d", m), act_data[m], 0);
      check($sformatf("mid_rst_abort%0d", m), act_ab[m], 0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(32'h81, 8);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("post_rst_data", act_data[0], 8'h81);
    check("post_rst_valid", act_valid[0], 1);
    check("post_rst_no_abort", ab_count, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      step(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 599) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
